// File: rtl/spram_pkg.sv
// Shared types for the Wishbone single-port RAM.
// Holds the read-during-write mode enum, the zero-clear sequencer states,
// and the helper that maps the string-valued RDW_MODE parameter onto the enum.
package spram_pkg;

    // Value returned on the read port during a write access.
    typedef enum logic {
        RDW_READ_FIRST  = 1'b0,   // old word
        RDW_WRITE_FIRST = 1'b1    // word after the byte-lane merge
    } rdw_mode_e;

    // Post-reset sequencer: CLEAR walks the array writing zeros, READY serves the bus.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clear_state_e;

    // Anything other than "WRITE_FIRST" falls back to read-first behaviour.
    function automatic rdw_mode_e to_rdw_mode(input string mode);
        if (mode == "WRITE_FIRST") begin
            return RDW_WRITE_FIRST;
        end
        return RDW_READ_FIRST;
    endfunction

endpackage

// File: rtl/spram_core.sv
// Raw byte-enabled single-port RAM array with a registered read port.
// Latency: q_o updates on the clock edge after ce_i; it holds while ce_i is low.
// Backpressure: none, one access per cycle whenever ce_i is high.
//
// Ports:
//   clk    : clock
//   ce_i   : access enable (read, and write of the lanes selected by we_i)
//   we_i   : per-byte write enables
//   addr_i : word address, must be < DEPTH when ce_i is high
//   d_i    : write data
//   q_o    : read data (old or merged word, depending on RDW_MODE)
module spram_core
    import spram_pkg::*;
#(
    parameter int        DATA_WIDTH = 32,
    parameter int        DEPTH      = 1024,
    parameter int        ADDR_WIDTH = $clog2(DEPTH),
    parameter rdw_mode_e RDW_MODE   = RDW_READ_FIRST,
    parameter string     INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    ce_i,
    input  logic [DATA_WIDTH/8-1:0] we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   d_i,
    output logic [DATA_WIDTH-1:0]   q_o
);

    localparam int NB = DATA_WIDTH / 8;

    (* ram_decomp = "power" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] q_q;

    // Word as it will look after this access's lane writes.
    always_comb begin
        merged = mem[addr_i];
        for (int i = 0; i < NB; i++) begin
            if (we_i[i]) begin
                merged[8*i +: 8] = d_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ce_i) begin
            for (int i = 0; i < NB; i++) begin
                if (we_i[i]) begin
                    mem[addr_i][8*i +: 8] <= d_i[8*i +: 8];
                end
            end
            if (RDW_MODE == RDW_WRITE_FIRST) begin
                q_q <= merged;
            end else begin
                q_q <= mem[addr_i];
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/spram_wb.sv
// Single-port RAM behind a Wishbone B4 pipelined slave, with optional zero-clear after reset.
// Latency: ack/err exactly 1+OUT_REG cycles after accept, in order, one access per cycle.
// Backpressure: wb_stall only during the post-reset zero-clear; responses killed when wb_cyc drops.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   wb_cyc, wb_stb    : bus cycle / strobe (accept = cyc & stb & !stall)
//   wb_we, wb_sel     : write enable and byte-lane selects
//   wb_adr, wb_dat_i  : word address and write data
//   wb_dat_o          : read data (held between responses, 0 on error)
//   wb_ack, wb_err    : access complete / access to address >= DEPTH
//   wb_stall, busy    : request refused this cycle / zero-clear running
module spram_wb
    import spram_pkg::*;
#(
    parameter int    DATA_WIDTH = 32,
    parameter int    SIZE       = 'h1000,
    parameter int    DEPTH      = SIZE / (DATA_WIDTH / 8),
    parameter int    ADDR_WIDTH = $clog2(DEPTH),
    parameter int    OUT_REG    = 0,
    parameter string RDW_MODE   = "READ_FIRST",
    parameter int    ZERO_CLEAR = 0,
    parameter string INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [DATA_WIDTH/8-1:0] wb_sel,
    input  logic [ADDR_WIDTH-1:0]   wb_adr,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack,
    output logic                    wb_err,
    output logic                    wb_stall,
    output logic                    busy
);

    localparam int        NB      = DATA_WIDTH / 8;
    localparam rdw_mode_e RDW     = to_rdw_mode(RDW_MODE);
    // A preload image takes priority over clearing.
    localparam bit        CLR_EN  = (ZERO_CLEAR != 0) && (INIT_FILE == "");
    localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(DEPTH - 1);

    // ---------------------------------------------------------------------
    // Zero-clear sequencer
    // ---------------------------------------------------------------------
    clear_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clearing;

    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLR_EN) begin
                state_q <= ST_CLEAR;
            end else begin
                state_q <= ST_READY;
            end
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clearing = 1'b0;
        busy     = 1'b0;
        wb_stall = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clearing = 1'b1;
                busy     = 1'b1;
                wb_stall = 1'b1;
                if (cnt_q == LAST_ADR) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------------
    logic accept;
    logic in_range;

    // Requests presented while rst is high are not taken; the pipeline is being flushed anyway.
    assign accept   = wb_cyc & wb_stb & ~wb_stall & ~rst;
    assign in_range = (32'(wb_adr) < 32'(DEPTH));

    logic                  core_ce;
    logic [NB-1:0]         core_we;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_d;
    logic [DATA_WIDTH-1:0] core_q;

    // The clear walk and bus traffic never overlap: the bus is stalled while clearing.
    always_comb begin
        core_ce   = 1'b0;
        core_we   = '0;
        core_addr = wb_adr;
        core_d    = wb_dat_i;
        if (clearing && !rst) begin
            core_ce   = 1'b1;
            core_we   = '1;
            core_addr = cnt_q;
            core_d    = '0;
        end else if (accept && in_range) begin
            core_ce = 1'b1;
            core_we = wb_we ? wb_sel : '0;
        end
    end

    spram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RDW_MODE   (RDW),
        .INIT_FILE  (INIT_FILE)
    ) u_core (
        .clk    (clk),
        .ce_i   (core_ce),
        .we_i   (core_we),
        .addr_i (core_addr),
        .d_i    (core_d),
        .q_o    (core_q)
    );

    // ---------------------------------------------------------------------
    // Response pipeline
    // ---------------------------------------------------------------------
    logic                  v1_q, v1_d;
    logic                  e1_q, e1_d;
    logic                  issue1;
    logic [DATA_WIDTH-1:0] rsp_dat;

    assign v1_d = accept;
    assign e1_d = accept & ~in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            e1_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            e1_q <= e1_d;
        end
    end

    // Dropping wb_cyc abandons everything in flight, so each stage is gated by it.
    assign issue1  = v1_q & wb_cyc;
    // Out-of-range accesses never enable the core, so its q is stale: force zero.
    assign rsp_dat = e1_q ? '0 : core_q;

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                  v2_q, v2_d;
            logic                  e2_q, e2_d;
            logic [DATA_WIDTH-1:0] dat2_q, dat2_d;

            assign v2_d   = issue1;
            assign e2_d   = e1_q;
            assign dat2_d = issue1 ? rsp_dat : dat2_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v2_q   <= 1'b0;
                    e2_q   <= 1'b0;
                    dat2_q <= '0;
                end else begin
                    v2_q   <= v2_d;
                    e2_q   <= e2_d;
                    dat2_q <= dat2_d;
                end
            end

            assign wb_ack   = v2_q & ~e2_q & wb_cyc;
            assign wb_err   = v2_q &  e2_q & wb_cyc;
            assign wb_dat_o = dat2_q;
        end else begin : g_noreg
            // Core q is consumed directly in the response cycle; hold_q keeps it afterwards
            // so wb_dat_o does not move when no response is issued.
            logic [DATA_WIDTH-1:0] hold_q, hold_d;

            assign hold_d = issue1 ? rsp_dat : hold_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_q <= '0;
                end else begin
                    hold_q <= hold_d;
                end
            end

            assign wb_ack   = issue1 & ~e1_q;
            assign wb_err   = issue1 &  e1_q;
            assign wb_dat_o = issue1 ? rsp_dat : hold_q;
        end
    endgenerate

endmodule

// File: tb/tb_spram_wb.sv
module tb_spram_wb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- DUT A: DEPTH=1000, OUT_REG=0, READ_FIRST ----------------
    logic        a_rst, a_cyc, a_stb, a_we;
    logic [3:0]  a_sel;
    logic [9:0]  a_adr;
    logic [31:0] a_dati, a_dato;
    logic        a_ack, a_err, a_stall, a_busy;

    spram_wb #(
        .DATA_WIDTH (32),
        .SIZE       (4000),
        .OUT_REG    (0),
        .RDW_MODE   ("READ_FIRST"),
        .ZERO_CLEAR (0)
    ) u_a (
        .clk      (clk),
        .rst      (a_rst),
        .wb_cyc   (a_cyc),
        .wb_stb   (a_stb),
        .wb_we    (a_we),
        .wb_sel   (a_sel),
        .wb_adr   (a_adr),
        .wb_dat_i (a_dati),
        .wb_dat_o (a_dato),
        .wb_ack   (a_ack),
        .wb_err   (a_err),
        .wb_stall (a_stall),
        .busy     (a_busy)
    );

    // ---------------- DUT B: DEPTH=16, OUT_REG=1, WRITE_FIRST, zero-clear ----------------
    logic        b_rst, b_cyc, b_stb, b_we;
    logic [3:0]  b_sel;
    logic [3:0]  b_adr;
    logic [31:0] b_dati, b_dato;
    logic        b_ack, b_err, b_stall, b_busy;

    spram_wb #(
        .DATA_WIDTH (32),
        .SIZE       (64),
        .OUT_REG    (1),
        .RDW_MODE   ("WRITE_FIRST"),
        .ZERO_CLEAR (1)
    ) u_b (
        .clk      (clk),
        .rst      (b_rst),
        .wb_cyc   (b_cyc),
        .wb_stb   (b_stb),
        .wb_we    (b_we),
        .wb_sel   (b_sel),
        .wb_adr   (b_adr),
        .wb_dat_i (b_dati),
        .wb_dat_o (b_dato),
        .wb_ack   (b_ack),
        .wb_err   (b_err),
        .wb_stall (b_stall),
        .busy     (b_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- table for DUT A ----------------
    typedef struct {
        logic        cyc;
        logic        we;
        logic [3:0]  sel;
        logic [9:0]  adr;
        logic [31:0] dat;
        logic        ack;
        logic        err;
        logic        chk_dat;
        logic [31:0] rdat;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    // ---------------- burst queue for DUT B ----------------
    logic        bq_we  [32];
    logic [3:0]  bq_sel [32];
    logic [3:0]  bq_adr [32];
    logic [31:0] bq_dat [32];
    logic [31:0] bq_exp [32];
    int          bn = 0;

    task automatic bop(input logic we, input logic [3:0] sel, input logic [3:0] adr,
                       input logic [31:0] dat, input logic [31:0] exp);
        bq_we[bn]  = we;
        bq_sel[bn] = sel;
        bq_adr[bn] = adr;
        bq_dat[bn] = dat;
        bq_exp[bn] = exp;
        bn++;
    endtask

    // Issues the queued ops back to back; each response is expected exactly two cycles later.
    task automatic burst_b(input string tag);
        int j;
        for (int k = 0; k < bn + 4; k++) begin
            @(posedge clk);
            #1;
            b_cyc = 1'b1;
            if (k < bn) begin
                b_stb  = 1'b1;
                b_we   = bq_we[k];
                b_sel  = bq_sel[k];
                b_adr  = bq_adr[k];
                b_dati = bq_dat[k];
            end else begin
                b_stb = 1'b0;
                b_we  = 1'b0;
            end
            @(negedge clk);
            if (k < bn) chk({tag, "_stall"}, 32'(b_stall), 32'd0);
            j = k - 2;
            if (j >= 0 && j < bn) begin
                chk($sformatf("%s_ack%0d", tag, j), 32'(b_ack), 32'd1);
                chk($sformatf("%s_err%0d", tag, j), 32'(b_err), 32'd0);
                chk($sformatf("%s_dat%0d", tag, j), b_dato, bq_exp[j]);
            end else begin
                chk($sformatf("%s_idle_ack%0d", tag, k), 32'(b_ack), 32'd0);
            end
        end
        bn = 0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (b_busy && b_stall) n++;
            else break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;

        vt[0]  = '{1'b1, 1'b1, 4'hF, 10'd5,    32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b1, 4'h2, 10'd5,    32'h0000AA00, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 1'b0, 4'hF, 10'd5,    32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADAAEF};
        vt[3]  = '{1'b1, 1'b1, 4'hF, 10'd7,    32'h11111111, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[4]  = '{1'b1, 1'b1, 4'hF, 10'd7,    32'h22222222, 1'b1, 1'b0, 1'b1, 32'h11111111};
        vt[5]  = '{1'b1, 1'b0, 4'h0, 10'd7,    32'h0,        1'b1, 1'b0, 1'b1, 32'h22222222};
        vt[6]  = '{1'b1, 1'b1, 4'h0, 10'd5,    32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hDEADAAEF};
        vt[7]  = '{1'b0, 1'b1, 4'hF, 10'd5,    32'h00000000, 1'b0, 1'b0, 1'b1, 32'hDEADAAEF};
        vt[8]  = '{1'b1, 1'b0, 4'hF, 10'd5,    32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADAAEF};
        vt[9]  = '{1'b1, 1'b1, 4'hF, 10'd977,  32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[10] = '{1'b1, 1'b0, 4'hF, 10'd1000, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0};
        vt[11] = '{1'b1, 1'b1, 4'hF, 10'd1001, 32'h12345678, 1'b0, 1'b1, 1'b1, 32'h0};
        vt[12] = '{1'b1, 1'b0, 4'hF, 10'd977,  32'h0,        1'b1, 1'b0, 1'b1, 32'hCAFEF00D};
        vt[13] = '{1'b1, 1'b1, 4'hF, 10'd1023, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 32'h0};
        vt[14] = '{1'b1, 1'b1, 4'hF, 10'd999,  32'h01020304, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[15] = '{1'b1, 1'b1, 4'h9, 10'd999,  32'hAABBCCDD, 1'b1, 1'b0, 1'b1, 32'h01020304};
        vt[16] = '{1'b1, 1'b0, 4'hF, 10'd999,  32'h0,        1'b1, 1'b0, 1'b1, 32'hAA0203DD};

        a_rst = 1'b1; a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0;
        a_sel = '0; a_adr = '0; a_dati = '0;
        b_rst = 1'b1; b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
        b_sel = '0; b_adr = '0; b_dati = '0;

        // ---- reset values ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("a_rst_ack", 32'(a_ack), 32'd0);
        chk("a_rst_err", 32'(a_err), 32'd0);
        chk("a_rst_dat", a_dato, 32'd0);
        chk("b_rst_ack", 32'(b_ack), 32'd0);
        chk("b_rst_err", 32'(b_err), 32'd0);
        chk("b_rst_dat", b_dato, 32'd0);
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;

        // ---- B: initial zero-clear length; A has no clear ----
        count_busy(nb);
        chk("b_clear_len", 32'(nb), 32'd16);
        chk("a_busy", 32'(a_busy), 32'd0);
        chk("a_stall", 32'(a_stall), 32'd0);

        // ---- A: table of single accesses ----
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            a_cyc  = vt[i].cyc;
            a_stb  = 1'b1;
            a_we   = vt[i].we;
            a_sel  = vt[i].sel;
            a_adr  = vt[i].adr;
            a_dati = vt[i].dat;
            @(posedge clk);
            #1;
            a_cyc = 1'b1;
            a_stb = 1'b0;
            a_we  = 1'b0;
            @(negedge clk);
            chk($sformatf("a_v%0d_ack", i), 32'(a_ack), 32'(vt[i].ack));
            chk($sformatf("a_v%0d_err", i), 32'(a_err), 32'(vt[i].err));
            if (vt[i].chk_dat) chk($sformatf("a_v%0d_dat", i), a_dato, vt[i].rdat);
            @(negedge clk);
            chk($sformatf("a_v%0d_ack_after", i), 32'(a_ack), 32'd0);
            chk($sformatf("a_v%0d_err_after", i), 32'(a_err), 32'd0);
            if (vt[i].chk_dat) chk($sformatf("a_v%0d_hold", i), a_dato, vt[i].rdat);
        end
        a_cyc = 1'b0;

        // ---- B: fill with ones, then reset mid-clear ----
        for (int w = 0; w < 16; w++) bop(1'b1, 4'hF, 4'(w), 32'hFFFFFFFF, 32'hFFFFFFFF);
        burst_b("b_fill");
        @(posedge clk);
        #1;
        b_cyc = 1'b0;
        b_rst = 1'b1;
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("b_clr_busy%0d", k), 32'(b_busy), 32'd1);
        end
        @(posedge clk);
        #1;
        b_rst = 1'b1;
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        count_busy(nb);
        chk("b_clear_restart_len", 32'(nb), 32'd16);

        // ---- B: everything reads zero, back to back ----
        for (int w = 0; w < 16; w++) bop(1'b0, 4'hF, 4'(w), 32'h0, 32'h0);
        burst_b("b_zero");

        // ---- B: preload 0x10..0x13, back-to-back reads, write-first data ----
        for (int w = 0; w < 4; w++) bop(1'b1, 4'hF, 4'(w), 32'h10 + 32'(w), 32'h10 + 32'(w));
        for (int w = 0; w < 4; w++) bop(1'b0, 4'hF, 4'(w), 32'h0, 32'h10 + 32'(w));
        bop(1'b1, 4'hF, 4'd7, 32'h11111111, 32'h11111111);
        bop(1'b1, 4'hF, 4'd7, 32'h22222222, 32'h22222222);
        bop(1'b1, 4'h1, 4'd7, 32'h000000AB, 32'h222222AB);
        burst_b("b_rw");

        // ---- B: write then read accepted, wb_cyc dropped -> both responses killed ----
        @(posedge clk);
        #1;
        b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b1; b_sel = 4'hF; b_adr = 4'd9; b_dati = 32'h99;
        @(posedge clk);
        #1;
        b_we = 1'b0; b_adr = 4'd1; b_dati = 32'h0;
        @(posedge clk);
        #1;
        b_cyc = 1'b0; b_stb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("b_kill_ack%0d", k), 32'(b_ack), 32'd0);
            chk($sformatf("b_kill_err%0d", k), 32'(b_err), 32'd0);
            @(posedge clk);
            #1;
            if (k == 1) b_cyc = 1'b1;
        end
        bop(1'b0, 4'hF, 4'd9, 32'h0, 32'h99);
        burst_b("b_after_kill");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
